bram_rw_sequencer: RTL and testbench
====================================

BRAM_RW_SEQUENCER -- requirements
Module: bram_rw_sequencer

Interface
REQ-001 Parameter ADDR_W, default 10, BRAM address width; sweep covers 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 32, BRAM data width (>= ADDR_W).
REQ-003 Parameter START_DLY, default 4, idle cycles between accepted start and first write.
REQ-004 Parameter RD_LAT, default 2, BRAM read latency in cycles (1..4).
REQ-005 clk  in  1  single clock, all logic posedge.
REQ-006 rst  in  1  synchronous, active-low reset (rst=0 resets at next posedge).
REQ-007 start  in  1  level from VIO, rising edge (registered) begins a test run.
REQ-008 seed  in  DATA_W  pattern seed, sampled on accepted start.
REQ-009 bram_en  out  1  BRAM port enable.
REQ-010 bram_we  out  1  BRAM write enable.
REQ-011 bram_addr  out  ADDR_W  BRAM address.
REQ-012 bram_din  out  DATA_W  BRAM write data.
REQ-013 bram_dout  in  DATA_W  BRAM read data, valid RD_LAT cycles after read issue.
REQ-014 busy  out  1  high from accepted start until done asserts.
REQ-015 done  out  1  high in DONE state, held until next start or reset.
REQ-016 pass  out  1  valid when done=1; 1 iff err_cnt==0.
REQ-017 err_cnt  out  16  mismatch count, saturating at 16'hFFFF.
REQ-018 first_err_addr  out  ADDR_W  address of first mismatch; 0 if none.

Function
REQ-019 FSM states: IDLE, WAIT, WRITE, READ, DRAIN, DONE.
REQ-020 IDLE/DONE -> WAIT on start rising edge; seed latched; err_cnt, first_err_addr, pass, done cleared same edge.
REQ-021 WAIT: down-counter loaded START_DLY, -> WRITE when it reaches 0 (exactly START_DLY cycles in WAIT; START_DLY=0 -> one cycle).
REQ-022 WRITE: one write per cycle, addr 0..2^ADDR_W-1, bram_en=bram_we=1, bram_din = (seed + zero-extended addr) mod 2^DATA_W.
REQ-023 WRITE -> READ after last address; address counter wraps to 0, no idle cycle.
REQ-024 READ: one read per cycle, addr 0..max, bram_en=1, bram_we=0; -> DRAIN after last address.
REQ-025 DRAIN: lasts exactly RD_LAT cycles, bram_en=0, then -> DONE.
REQ-026 Compare pipeline: RD_LAT-deep shift of {valid, addr}; on valid, bram_dout compared against seed+addr.
REQ-027 Mismatch: err_cnt += 1 unless already 16'hFFFF; first_err_addr captured only when err_cnt==0.
REQ-028 start edges while busy=1 are ignored; start held high does not retrigger.
REQ-029 DONE: done=1, busy=0, pass=(err_cnt==0); outputs stable until next start edge.
REQ-030 bram_en=bram_we=0 in IDLE, WAIT, DRAIN, DONE.

Reset
REQ-031 rst=0: state IDLE; all outputs 0 (pass=0, done=0, busy=0, err_cnt=0, bram_*=0); pipeline valids cleared; start-edge register cleared.
REQ-032 Reset mid-run aborts at next posedge; no further BRAM access; no compare result from in-flight reads counted.

Structure
REQ-033 Package bram_seq_pkg holds FSM state enum and err_cnt width constant (16).
REQ-034 One sub-module, bram_rd_check: read-latency pipeline, comparator, saturating error counter, first-error capture.

Verification
REQ-035 ADDR_W=4, RD_LAT=2, ideal BRAM model, seed=32'h100, start pulse -> 16 writes data 0x100..0x10F, 16 reads, done=1, pass=1, err_cnt=0; total start-to-done START_DLY+16+16+2 cycles +1 sync.
REQ-036 Model corrupts addr 5 and 9 on read -> err_cnt=2, first_err_addr=5, pass=0.
REQ-037 Seed=32'hFFFF_FFFE, ADDR_W=4 -> din wraps to 0x0..0xD at addr 2..15, pass=1.
REQ-038 Model returns all-zero on every read, 2^ADDR_W > 65535 forced via err_cnt preload -> err_cnt holds 16'hFFFF.
REQ-039 Start toggled during WRITE, then held high -> no restart; after done, fresh edge restarts with cleared status.
REQ-040 rst=0 during READ -> next cycle bram_en=0, busy=0, err_cnt=0; later start runs cleanly to pass=1.

Source files
------------

// File: rtl/bram_seq_pkg.sv
// -----------------------------------------------------------------------------
// bram_seq_pkg
// Shared types and constants for the BRAM read/write sequencer.
//   seq_state_e : sequencer FSM state encoding
//   ErrCntW     : width of the saturating mismatch counter
// -----------------------------------------------------------------------------
package bram_seq_pkg;

   localparam int unsigned ErrCntW = 16;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StWrite,
      StRead,
      StDrain,
      StDone
   } seq_state_e;

endpackage : bram_seq_pkg

// File: rtl/bram_rd_check.sv
// -----------------------------------------------------------------------------
// bram_rd_check
// Read-latency pipeline and checker. Every issued read is tracked through an
// RD_LAT-deep shift of {valid, addr}; when a tracked read reaches the end of
// the pipe the returned BRAM word is compared against seed + addr.
//
// Ports
//   clk            in   clock, posedge
//   rst            in   synchronous active-low reset
//   clr            in   start of a new run: flush pipe, reload counter
//   rd_valid       in   a read is being issued this cycle
//   rd_addr        in   address of the read being issued
//   seed           in   pattern seed of the current run
//   bram_dout      in   BRAM read data, valid RD_LAT cycles after issue
//   err_cnt        out  saturating mismatch count
//   first_err_addr out  address of the first mismatch of the run, 0 if none
// -----------------------------------------------------------------------------
module bram_rd_check
   import bram_seq_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned RD_LAT      = 2,
   parameter int unsigned ERR_PRELOAD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 rd_valid,
   input  logic [ADDR_W-1:0]    rd_addr,
   input  logic [DATA_W-1:0]    seed,
   input  logic [DATA_W-1:0]    bram_dout,
   output logic [ErrCntW-1:0]   err_cnt,
   output logic [ADDR_W-1:0]    first_err_addr
);

   localparam logic [ErrCntW-1:0] ErrCntMax = '1;

   logic [RD_LAT-1:0] vld_q;
   logic [ADDR_W-1:0] addr_q [RD_LAT];
   logic [ErrCntW-1:0] err_cnt_q;
   logic [ADDR_W-1:0] first_err_q;

   logic [DATA_W-1:0] exp_data;
   logic              mismatch;

   assign exp_data = seed + DATA_W'(addr_q[RD_LAT-1]);
   assign mismatch = vld_q[RD_LAT-1] && (bram_dout != exp_data);

   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_q       <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            addr_q[i] <= '0;
         end
         err_cnt_q   <= '0;
         first_err_q <= '0;
      end else if (clr) begin
         // Nothing is in flight when a run is accepted; flushing just makes it explicit.
         vld_q       <= '0;
         err_cnt_q   <= ErrCntW'(ERR_PRELOAD);
         first_err_q <= '0;
      end else begin
         vld_q[0]  <= rd_valid;
         addr_q[0] <= rd_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i]  <= vld_q[i-1];
            addr_q[i] <= addr_q[i-1];
         end
         if (mismatch) begin
            if (err_cnt_q != ErrCntMax) begin
               err_cnt_q <= err_cnt_q + ErrCntW'(1);
            end
            // Only the very first mismatch of a run is recorded.
            if (err_cnt_q == '0) begin
               first_err_q <= addr_q[RD_LAT-1];
            end
         end
      end
   end

   assign err_cnt        = err_cnt_q;
   assign first_err_addr = first_err_q;

endmodule : bram_rd_check

// File: rtl/bram_rw_sequencer.sv
// -----------------------------------------------------------------------------
// bram_rw_sequencer
// Self-test sequencer for a single-port BRAM. A rising edge on start (after a
// one-flop sync stage) launches a run: a programmable idle delay, a full write
// sweep of seed + addr, a full read sweep, and a drain of RD_LAT cycles while
// the last reads return. Read data is checked by bram_rd_check.
//
// Ports
//   clk            in   clock, posedge
//   rst            in   synchronous active-low reset
//   start          in   level from VIO; a rising edge starts a run when idle
//   seed           in   pattern seed, sampled when a run is accepted
//   bram_en        out  BRAM port enable
//   bram_we        out  BRAM write enable
//   bram_addr      out  BRAM address
//   bram_din       out  BRAM write data
//   bram_dout      in   BRAM read data, RD_LAT cycles after read issue
//   busy           out  run in progress
//   done           out  run finished, held until next accepted start
//   pass           out  done and no mismatches
//   err_cnt        out  saturating mismatch count
//   first_err_addr out  address of first mismatch, 0 if none
//
// ERR_PRELOAD is the value the error counter starts a run from; it is 0 in
// normal use and lets saturation be exercised on a small address space.
// -----------------------------------------------------------------------------
module bram_rw_sequencer
   import bram_seq_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned START_DLY   = 4,
   parameter int unsigned RD_LAT      = 2,
   parameter int unsigned ERR_PRELOAD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DATA_W-1:0]    seed,
   output logic                 bram_en,
   output logic                 bram_we,
   output logic [ADDR_W-1:0]    bram_addr,
   output logic [DATA_W-1:0]    bram_din,
   input  logic [DATA_W-1:0]    bram_dout,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ErrCntW-1:0]   err_cnt,
   output logic [ADDR_W-1:0]    first_err_addr
);

   // WAIT lasts max(START_DLY, 1) cycles: the counter is loaded with one less
   // than the delay and the exit happens in the cycle it reads zero.
   localparam int unsigned       DlyW      = (START_DLY > 1) ? $clog2(START_DLY) : 1;
   localparam logic [DlyW-1:0]   DlyLoad   = (START_DLY == 0) ? '0 : DlyW'(START_DLY - 1);
   localparam logic [1:0]        DrainLoad = 2'(RD_LAT - 1);
   localparam logic [ADDR_W-1:0] AddrMax   = '1;

   seq_state_e        state_q;
   logic              start_sync_q;
   logic              start_prev_q;
   logic [DATA_W-1:0] seed_q;
   logic [DlyW-1:0]   dly_q;
   logic [1:0]        drain_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;
   logic              en_q;
   logic              we_q;
   logic              busy_q;
   logic              done_q;

   logic start_edge;
   logic start_accept;

   assign start_edge   = start_sync_q & ~start_prev_q;
   // Edges seen while a run is active are dropped, not queued.
   assign start_accept = start_edge && ((state_q == StIdle) || (state_q == StDone));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         start_sync_q <= 1'b0;
         start_prev_q <= 1'b0;
         seed_q       <= '0;
         dly_q        <= '0;
         drain_q      <= '0;
         addr_q       <= '0;
         din_q        <= '0;
         en_q         <= 1'b0;
         we_q         <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         start_sync_q <= start;
         start_prev_q <= start_sync_q;

         unique case (state_q)
            StIdle, StDone: begin
               if (start_edge) begin
                  state_q <= StWait;
                  seed_q  <= seed;
                  dly_q   <= DlyLoad;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end

            StWait: begin
               if (dly_q == '0) begin
                  state_q <= StWrite;
                  en_q    <= 1'b1;
                  we_q    <= 1'b1;
                  addr_q  <= '0;
                  din_q   <= seed_q;
               end else begin
                  dly_q <= dly_q - DlyW'(1);
               end
            end

            StWrite: begin
               if (addr_q == AddrMax) begin
                  // Straight into the read sweep with no bubble.
                  state_q <= StRead;
                  we_q    <= 1'b0;
                  addr_q  <= '0;
                  din_q   <= '0;
               end else begin
                  addr_q <= addr_q + ADDR_W'(1);
                  // din tracks seed + addr, so it simply increments with addr.
                  din_q  <= din_q + DATA_W'(1);
               end
            end

            StRead: begin
               if (addr_q == AddrMax) begin
                  state_q <= StDrain;
                  en_q    <= 1'b0;
                  addr_q  <= '0;
                  drain_q <= DrainLoad;
               end else begin
                  addr_q <= addr_q + ADDR_W'(1);
               end
            end

            StDrain: begin
               // The last compare lands on the same edge that enters DONE.
               if (drain_q == '0) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  drain_q <= drain_q - 2'd1;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   bram_rd_check #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .RD_LAT      (RD_LAT),
      .ERR_PRELOAD (ERR_PRELOAD)
   ) u_rd_check (
      .clk            (clk),
      .rst            (rst),
      .clr            (start_accept),
      .rd_valid       (en_q & ~we_q),
      .rd_addr        (addr_q),
      .seed           (seed_q),
      .bram_dout      (bram_dout),
      .err_cnt        (err_cnt),
      .first_err_addr (first_err_addr)
   );

   assign bram_en   = en_q;
   assign bram_we   = we_q;
   assign bram_addr = addr_q;
   assign bram_din  = din_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = done_q && (err_cnt == '0);

endmodule : bram_rw_sequencer

// File: tb/tb_bram_rw_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bram_rw_sequencer
// Directed bench for bram_rw_sequencer with ADDR_W=4, RD_LAT=2, START_DLY=4.
// A second instance with a preloaded error counter reads all-zero data so the
// counter saturation can be observed on a 16-word sweep.
// -----------------------------------------------------------------------------
module tb_bram_rw_sequencer;
   import bram_seq_pkg::*;

   localparam int unsigned ADDR_W    = 4;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned START_DLY = 4;
   localparam int unsigned RD_LAT    = 2;
   localparam int unsigned NWORDS    = 16;
   // Edges from the one that samples start high to the one that raises done.
   localparam int          EXP_LAT   = START_DLY + 2 * NWORDS + RD_LAT + 1;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic [DATA_W-1:0]  seed = '0;

   logic               bram_en, bram_we;
   logic [ADDR_W-1:0]  bram_addr;
   logic [DATA_W-1:0]  bram_din;
   logic [DATA_W-1:0]  bram_dout = '0;
   logic               busy, done, pass;
   logic [ErrCntW-1:0] err_cnt;
   logic [ADDR_W-1:0]  first_err_addr;

   logic               s_en, s_we, s_busy, s_done, s_pass;
   logic [ADDR_W-1:0]  s_addr, s_first;
   logic [DATA_W-1:0]  s_din;
   logic [ErrCntW-1:0] s_err;

   // BRAM model state
   logic [DATA_W-1:0]  mem [NWORDS];
   logic [DATA_W-1:0]  rd_stage = '0;
   logic               corrupt = 1'b0;
   int                 wr_total = 0;
   int                 rd_total = 0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bram_rw_sequencer #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .START_DLY (START_DLY),
      .RD_LAT    (RD_LAT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .seed           (seed),
      .bram_en        (bram_en),
      .bram_we        (bram_we),
      .bram_addr      (bram_addr),
      .bram_din       (bram_din),
      .bram_dout      (bram_dout),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_cnt        (err_cnt),
      .first_err_addr (first_err_addr)
   );

   bram_rw_sequencer #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .START_DLY   (START_DLY),
      .RD_LAT      (RD_LAT),
      .ERR_PRELOAD (32'hFFF8)
   ) u_sat (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .seed           (seed),
      .bram_en        (s_en),
      .bram_we        (s_we),
      .bram_addr      (s_addr),
      .bram_din       (s_din),
      .bram_dout      ('0),
      .busy           (s_busy),
      .done           (s_done),
      .pass           (s_pass),
      .err_cnt        (s_err),
      .first_err_addr (s_first)
   );

   // Ideal two-cycle BRAM, optionally flipping a bit on reads of addr 5 and 9.
   always @(posedge clk) begin
      if (bram_en) begin
         if (bram_we) begin
            mem[bram_addr] <= bram_din;
            wr_total       <= wr_total + 1;
         end else begin
            rd_total <= rd_total + 1;
            rd_stage <= mem[bram_addr] ^
                        ((corrupt && (bram_addr == 4'd5 || bram_addr == 4'd9)) ? 32'h40 : 32'h0);
         end
      end
      bram_dout <= rd_stage;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Fresh start edge, then wait for done; cyc counts negedges after the edge.
   task automatic run(output int cyc);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(cyc >= 3 && done === 1'b1) && cyc < 400);
      check_eq("run_done", done, 1'b1);
   endtask

   initial begin
      int cyc;
      int wr0;
      int rd0;

      // ---- reset state ----
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_en", bram_en, 1'b0);
      check_eq("rst_we", bram_we, 1'b0);
      check_eq("rst_addr", bram_addr, 0);
      check_eq("rst_din", bram_din, 0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_pass", pass, 1'b0);
      check_eq("rst_err", err_cnt, 0);
      check_eq("rst_first", first_err_addr, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("idle_busy", busy, 1'b0);

      // ---- clean run, seed 0x100 ----
      seed = 32'h100;
      wr0  = wr_total;
      rd0  = rd_total;
      run(cyc);
      check_eq("t1_latency", cyc - 1, EXP_LAT);
      check_eq("t1_writes", wr_total - wr0, NWORDS);
      check_eq("t1_reads", rd_total - rd0, NWORDS);
      check_eq("t1_mem0", mem[0], 32'h100);
      check_eq("t1_mem5", mem[5], 32'h105);
      check_eq("t1_mem15", mem[15], 32'h10F);
      check_eq("t1_busy", busy, 1'b0);
      check_eq("t1_pass", pass, 1'b1);
      check_eq("t1_err", err_cnt, 0);
      check_eq("t1_first", first_err_addr, 0);
      check_eq("t1_en_done", bram_en, 1'b0);
      check_eq("sat_err", s_err, 16'hFFFF);
      check_eq("sat_first", s_first, 0);
      check_eq("sat_pass", s_pass, 1'b0);
      check_eq("sat_done", s_done, 1'b1);
      repeat (5) @(negedge clk);
      check_eq("t1_done_hold", done, 1'b1);
      check_eq("t1_pass_hold", pass, 1'b1);

      // ---- corrupted reads at 5 and 9 ----
      corrupt = 1'b1;
      run(cyc);
      check_eq("t2_err", err_cnt, 2);
      check_eq("t2_first", first_err_addr, 5);
      check_eq("t2_pass", pass, 1'b0);
      corrupt = 1'b0;

      // ---- seed wrap ----
      seed = 32'hFFFF_FFFE;
      run(cyc);
      check_eq("t3_mem0", mem[0], 32'hFFFF_FFFE);
      check_eq("t3_mem1", mem[1], 32'hFFFF_FFFF);
      check_eq("t3_mem2", mem[2], 32'h0);
      check_eq("t3_mem15", mem[15], 32'hD);
      check_eq("t3_pass", pass, 1'b1);
      check_eq("t3_err", err_cnt, 0);

      // ---- start toggled during WRITE, then held high ----
      seed    = 32'h100;
      corrupt = 1'b1;
      wr0     = wr_total;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 10) begin
            check_eq("t4_in_write", bram_we, 1'b1);
            start = 1'b0;
         end
         if (cyc == 12) start = 1'b1;
      end while (!(cyc >= 3 && done === 1'b1) && cyc < 400);
      check_eq("t4_done", done, 1'b1);
      check_eq("t4_latency", cyc - 1, EXP_LAT);
      check_eq("t4_writes", wr_total - wr0, NWORDS);
      check_eq("t4_err", err_cnt, 2);
      repeat (6) @(negedge clk);
      check_eq("t4_held_done", done, 1'b1);
      check_eq("t4_held_busy", busy, 1'b0);
      // Fresh edge clears status on acceptance.
      corrupt = 1'b0;
      start   = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("t4_re_busy", busy, 1'b1);
      check_eq("t4_re_done", done, 1'b0);
      check_eq("t4_re_pass", pass, 1'b0);
      check_eq("t4_re_err", err_cnt, 0);
      check_eq("t4_re_first", first_err_addr, 0);
      cyc = 0;
      while (done !== 1'b1 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("t4_re_pass_end", pass, 1'b1);

      // ---- reset during READ ----
      corrupt = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      cyc = 0;
      while (err_cnt == 0 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("t5_err_pre", err_cnt, 1);
      check_eq("t5_in_read", {bram_en, bram_we}, 2'b10);
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_eq("t5_en", bram_en, 1'b0);
      check_eq("t5_busy", busy, 1'b0);
      check_eq("t5_err", err_cnt, 0);
      check_eq("t5_done", done, 1'b0);
      rst = 1'b1;
      rd0 = rd_total;
      repeat (6) @(negedge clk);
      check_eq("t5_no_reads", rd_total - rd0, 0);
      check_eq("t5_err_after", err_cnt, 0);
      check_eq("t5_first_after", first_err_addr, 0);
      check_eq("t5_idle_en", bram_en, 1'b0);
      corrupt = 1'b0;
      run(cyc);
      check_eq("t5_latency", cyc - 1, EXP_LAT);
      check_eq("t5_pass", pass, 1'b1);
      check_eq("t5_err_end", err_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_bram_rw_sequencer
